// File: rtl/mem_read_scheduler.sv
// Read-port arbiter for instr0 fetch and mfu0 operand reads, with an in-order tag FIFO
// that routes returning data. Optional anti-starvation guard: CRAY_RDSCHED_STARVE_GUARD_EN.
module mem_read_scheduler #(
    parameter int unsigned ADDR_W       = 22,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TAG_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_instr0_addr,
    input  logic              i_instr0_req,
    output logic              o_instr0_addr_ack,
    output logic              o_instr0_ack,
    output logic [DATA_W-1:0] o_read_instr0_data,

    input  logic [ADDR_W-1:0] i_mfu0_rd_addr,
    input  logic              i_mfu0_rd_req,
    output logic              o_mfu0_rd_addr_ack,
    output logic              o_mfu0_rd_ack,
    output logic [DATA_W-1:0] o_read_mfu0_data,

    output logic [ADDR_W-1:0] o_mem_rd_addr,
    output logic              o_mem_rd_req,
    input  logic              i_mem_rd_addr_ack,
    input  logic              i_mem_rd_ack,
    input  logic [DATA_W-1:0] i_mem_data,

    output logic              o_err
);

    localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StGntI, StGntM} state_e;

    state_e              state_q;
    logic [TAG_DEPTH-1:0] tag_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]     count_q;

    logic fifo_full;
    logic fifo_empty;
    logic addr_accept;
    logic push;
    logic pop;
    logic head_tag;
    logic starve_hit;
    logic grant_i;
    logic grant_m;

    assign fifo_full  = (count_q == CntW'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);

    // The request to memory follows the winner's live request so an abort drops it at once.
    assign o_mem_rd_req = ((state_q == StGntI) && i_instr0_req) ||
                          ((state_q == StGntM) && i_mfu0_rd_req);

    assign addr_accept        = o_mem_rd_req && i_mem_rd_addr_ack;
    assign o_instr0_addr_ack  = addr_accept && (state_q == StGntI);
    assign o_mfu0_rd_addr_ack = addr_accept && (state_q == StGntM);

    assign push     = addr_accept;
    assign pop      = i_mem_rd_ack && !fifo_empty;
    assign head_tag = tag_q[rd_ptr_q];

    assign grant_m = (state_q == StIdle) && !fifo_full && i_mfu0_rd_req &&
                     !(starve_hit && i_instr0_req);
    assign grant_i = (state_q == StIdle) && !fifo_full && i_instr0_req && !grant_m;

`ifdef CRAY_RDSCHED_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q;

    assign starve_hit = (starve_q >= StarveW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (!i_instr0_req || grant_i) begin
            starve_q <= '0;
        end else if (o_mfu0_rd_addr_ack && !starve_hit) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    logic unused_starve_limit;

    assign starve_hit          = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // Grant FSM; the address register is loaded on entry and cleared on exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            o_mem_rd_addr <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_m) begin
                        state_q       <= StGntM;
                        o_mem_rd_addr <= i_mfu0_rd_addr;
                    end else if (grant_i) begin
                        state_q       <= StGntI;
                        o_mem_rd_addr <= i_instr0_addr;
                    end
                end
                StGntI: begin
                    if (!i_instr0_req || i_mem_rd_addr_ack) begin
                        state_q       <= StIdle;
                        o_mem_rd_addr <= '0;
                    end
                end
                StGntM: begin
                    if (!i_mfu0_rd_req || i_mem_rd_addr_ack) begin
                        state_q       <= StIdle;
                        o_mem_rd_addr <= '0;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    o_mem_rd_addr <= '0;
                end
            endcase
        end
    end

    // Tag FIFO: 0 marks an instr0 read, 1 an mfu0 read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= (state_q == StGntM);
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_instr0_ack       <= 1'b0;
            o_mfu0_rd_ack      <= 1'b0;
            o_read_instr0_data <= '0;
            o_read_mfu0_data   <= '0;
            o_err              <= 1'b0;
        end else begin
            o_instr0_ack  <= pop && !head_tag;
            o_mfu0_rd_ack <= pop && head_tag;
            if (pop && !head_tag) begin
                o_read_instr0_data <= i_mem_data;
            end
            if (pop && head_tag) begin
                o_read_mfu0_data <= i_mem_data;
            end
            if (i_mem_rd_ack && fifo_empty) begin
                o_err <= 1'b1;
            end
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (!rst)
        count_q <= CntW'(TAG_DEPTH));

    a_addr_ack_excl : assert property (@(posedge clk) disable iff (!rst)
        !(o_instr0_addr_ack && o_mfu0_rd_addr_ack));

endmodule

// File: doc/mem_read_scheduler.md
# mem_read_scheduler

Sequenced arbiter for the single memory read port, shared by instruction fetch (instr0) and the memory functional unit read path (mfu0). Holds each grant stable until the memory accepts the address, tracks outstanding reads in an in-order tag FIFO, and routes each returning data word and ack to the requester that issued it. Sits between the CPU front end and the memory read port, in place of a purely combinational read mux.

## Interface
- ADDR_W, 22, address width
- DATA_W, 64, data word width
- TAG_DEPTH, 4, maximum outstanding reads (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive mfu0 grants tolerated while instr0 waits (guard build only)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_instr0_addr  in  ADDR_W  fetch address
- i_instr0_req  in  1  fetch request, held until o_instr0_addr_ack
- o_instr0_addr_ack  out  1  fetch address accepted by memory
- o_instr0_ack  out  1  fetch data valid (1-cycle pulse)
- o_read_instr0_data  out  DATA_W  fetch data
- i_mfu0_rd_addr  in  ADDR_W  operand read address
- i_mfu0_rd_req  in  1  operand read request, held until o_mfu0_rd_addr_ack
- o_mfu0_rd_addr_ack  out  1  operand address accepted
- o_mfu0_rd_ack  out  1  operand data valid (1-cycle pulse)
- o_read_mfu0_data  out  DATA_W  operand data
- o_mem_rd_addr  out  ADDR_W  memory read address
- o_mem_rd_req  out  1  memory read request
- i_mem_rd_addr_ack  in  1  memory accepted address
- i_mem_rd_ack  in  1  memory returns data (in issue order)
- i_mem_data  in  DATA_W  memory read data
- o_err  out  1  sticky: data returned with no outstanding tag

## Operation
- States: IDLE, GNT_I, GNT_M.
- IDLE: if tag count == TAG_DEPTH stay. Else mfu0 req → GNT_M; else instr0 req → GNT_I; else stay.
- GNT_x: o_mem_rd_req = winner's req; o_mem_rd_addr = winner's addr (0 in IDLE). Address held constant for whole grant.
- i_mem_rd_addr_ack counts only when o_mem_rd_req = 1: combinationally pulse winner's addr_ack, push tag (0 = instr0, 1 = mfu0), return to IDLE.
- Winner drops req before addr_ack: o_mem_rd_req falls same cycle, no push, return to IDLE.
- Loser's addr_ack always 0.
- i_mem_rd_ack with FIFO non-empty: pop head tag; next cycle pulse the tagged requester's ack and register i_mem_data into its data output; other requester's data holds last value.
- i_mem_rd_ack with FIFO empty: ignored, o_err set until reset.
- Push and pop in same cycle: count unchanged.
- Reset mid-operation: state → IDLE, FIFO emptied, in-flight returns dropped (later acks set o_err).

## Timing
- Reset values: all outputs 0; state IDLE; count 0; starve counter 0.
- Request in IDLE → o_mem_rd_req high next cycle.
- Address handshake: addr_ack zero-latency combinational from i_mem_rd_addr_ack.
- One IDLE bubble after each accepted address: peak one issue per 2 cycles.
- Data return: o_*_ack and data exactly 1 cycle after i_mem_rd_ack.
- Back-to-back i_mem_rd_ack every cycle supported.

## Configuration
- CRAY_RDSCHED_STARVE_GUARD_EN defined: counter increments on each accepted mfu0 address while instr0 req is high, clears on instr0 grant or when instr0 req low; at STARVE_LIMIT, IDLE grants instr0 even if mfu0 requests.
- Undefined: strict mfu0 priority, no counter; instr0 may starve indefinitely.

## Test plan
- Single fetch: instr0 req addr 0x00100, addr_ack after 2 cycles, rd_ack 3 cycles later with data 0xDEAD → o_instr0_addr_ack one pulse, o_instr0_ack 1 cycle after rd_ack, data 0xDEAD; mfu0 acks stay 0.
- Contention: both req in IDLE → GNT_M first (mfu0 addr on port), then instr0 after IDLE bubble; returns in order map tags 1,0 to mfu0 then instr0.
- FIFO full: 4 accepted addresses without returns → 5th request held in IDLE, o_mem_rd_req 0; one rd_ack → grant resumes next cycle.
- Abort: mfu0 drops req in GNT_M before addr_ack → o_mem_rd_req falls same cycle, count unchanged, IDLE.
- Spurious rd_ack with empty FIFO → no requester ack, o_err 1 until rst low; async reset mid-grant clears all outputs immediately.
- Guard build, STARVE_LIMIT 8: mfu0 and instr0 continuously requesting → instr0 granted after exactly 8 mfu0 grants; non-guard build → instr0 never granted.
